// File: rtl/pipeline_memwb_skid_if.sv
// MEM->WB handshake and payload bundle for the MEM/WB skid register stage.
// slave is the stage itself; master is whoever drives MEM and consumes WB.
interface pipeline_memwb_skid_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RD_W  = 5
);
  // upstream (MEM) side
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [WIDTH-1:0] ALUResultM;
  logic [WIDTH-1:0] ReadDataM;
  logic [WIDTH-1:0] PCPlus4M;
  logic [RD_W-1:0]  RdM;
  logic             RegWriteM;
  logic [1:0]       ResultSrcM;
  logic             WD3SrcM;

  // downstream (WB) side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResultW;
  logic [WIDTH-1:0] ReadDataW;
  logic [WIDTH-1:0] PCPlus4W;
  logic [RD_W-1:0]  RdW;
  logic             RegWriteW;
  logic [1:0]       ResultSrcW;
  logic             WD3SrcW;

  modport slave (
    input  in_valid, flush, ALUResultM, ReadDataM, PCPlus4M, RdM,
           RegWriteM, ResultSrcM, WD3SrcM, out_ready,
    output in_ready, out_valid, ALUResultW, ReadDataW, PCPlus4W, RdW,
           RegWriteW, ResultSrcW, WD3SrcW
  );

  modport master (
    output in_valid, flush, ALUResultM, ReadDataM, PCPlus4M, RdM,
           RegWriteM, ResultSrcM, WD3SrcM, out_ready,
    input  in_ready, out_valid, ALUResultW, ReadDataW, PCPlus4W, RdW,
           RegWriteW, ResultSrcW, WD3SrcW
  );
endinterface

// File: rtl/pipeline_memwb_skid.sv
// MEM/WB pipeline register with a one-entry skid buffer: full throughput,
// one-cycle latency, and in_ready decoupled from out_ready by registering it.
module pipeline_memwb_skid #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RD_W  = 5
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_memwb_skid_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] pc_plus4;
    logic [RD_W-1:0]  rd;
    logic             reg_write;
    logic [1:0]       result_src;
    logic             wd3_src;
  } payload_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t   r_state;
  state_t   w_next;
  logic     r_in_ready;
  logic     r_out_valid;
  payload_t r_main;
  payload_t r_skid;
  payload_t w_in;

  logic w_accept;
  logic w_fire;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;
  logic w_clr_main;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_fire   = r_out_valid & bus.out_ready;

  // Incoming payload; writes to x0 are squashed at capture time.
  always_comb begin
    w_in            = '0;
    w_in.alu_result = bus.ALUResultM;
    w_in.read_data  = bus.ReadDataM;
    w_in.pc_plus4   = bus.PCPlus4M;
    w_in.rd         = bus.RdM;
    w_in.reg_write  = bus.RegWriteM & (bus.RdM != RD_W'(0));
    w_in.result_src = bus.ResultSrcM;
    w_in.wd3_src    = bus.WD3SrcM;
  end

  // State register together with the registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next != S_FULL);
      r_out_valid <= (w_next != S_EMPTY);
    end
  end

  // Next-state and entry-load decode; flush overrides any accept/fire.
  always_comb begin
    w_next           = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    w_clr_main       = 1'b0;
    if (bus.flush) begin
      w_next     = S_EMPTY;
      w_clr_main = 1'b1;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_next         = S_ONE;
            w_load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (w_accept && w_fire) begin
            w_load_main_in = 1'b1;
          end else if (w_fire) begin
            w_next     = S_EMPTY;
            w_clr_main = 1'b1;
          end else if (w_accept) begin
            w_next      = S_FULL;
            w_load_skid = 1'b1;
          end
        end
        S_FULL: begin
          if (w_fire) begin
            w_next           = S_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: begin
          w_next     = S_EMPTY;
          w_clr_main = 1'b1;
        end
      endcase
    end
  end

  // Payload entries; main is cleared of its write enable whenever it drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= w_in;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end else if (w_clr_main) begin
        r_main.reg_write <= 1'b0;
      end
      if (w_load_skid) begin
        r_skid <= w_in;
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.ALUResultW = r_main.alu_result;
  assign bus.ReadDataW  = r_main.read_data;
  assign bus.PCPlus4W   = r_main.pc_plus4;
  assign bus.RdW        = r_main.rd;
  assign bus.RegWriteW  = r_main.reg_write;
  assign bus.ResultSrcW = r_main.result_src;
  assign bus.WD3SrcW    = r_main.wd3_src;

endmodule

// File: tb/tb_pipeline_memwb_skid.sv
// Scoreboard bench for pipeline_memwb_skid: driver pushes accepted payloads,
// a negedge monitor compares the WB side against the queue head.
module tb_pipeline_memwb_skid;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  rsrc;
    logic        wd3;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   level;
  exp_t sb_q[$];

  pipeline_memwb_skid_if #(.WIDTH(32), .RD_W(5)) bus ();

  pipeline_memwb_skid #(.WIDTH(32), .RD_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: queue holds what the stage should currently contain, oldest first.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", 32'(bus.out_valid), 32'(sb_q.size() != 0));
      check("in_ready", 32'(bus.in_ready), 32'(sb_q.size() < 2));
      if (sb_q.size() == 0) begin
        check("regwrite_idle", 32'(bus.RegWriteW), 32'd0);
      end else begin
        check("alu_w", bus.ALUResultW, sb_q[0].alu);
        check("rdata_w", bus.ReadDataW, sb_q[0].rdata);
        check("pc4_w", bus.PCPlus4W, sb_q[0].pc4);
        check("rd_w", 32'(bus.RdW), 32'(sb_q[0].rd));
        check("regwrite_w", 32'(bus.RegWriteW), 32'(sb_q[0].rw));
        check("rsrc_w", 32'(bus.ResultSrcW), 32'(sb_q[0].rsrc));
        check("wd3_w", 32'(bus.WD3SrcW), 32'(sb_q[0].wd3));
        if (bus.out_ready && !bus.flush) void'(sb_q.pop_front());
      end
    end
  end

  // One cycle of stimulus, applied just after an edge; model updates at the next edge.
  task automatic step(input bit v, input logic [31:0] alu, input logic [4:0] rd,
                      input bit rw, input bit ordy, input bit fl);
    exp_t e;
    bit   acc;
    bit   fr;
    e.alu   = alu;
    e.rdata = $urandom;
    e.pc4   = $urandom;
    e.rd    = rd;
    e.rw    = rw && (rd != 5'd0);
    e.rsrc  = 2'($urandom);
    e.wd3   = 1'($urandom);
    bus.in_valid   = v;
    bus.ALUResultM = alu;
    bus.ReadDataM  = e.rdata;
    bus.PCPlus4M   = e.pc4;
    bus.RdM        = rd;
    bus.RegWriteM  = rw;
    bus.ResultSrcM = e.rsrc;
    bus.WD3SrcM    = e.wd3;
    bus.out_ready  = ordy;
    bus.flush      = fl;
    @(posedge clk);
    acc = v && (level < 2);
    fr  = (level > 0) && ordy;
    if (fl) begin
      sb_q.delete();
      level = 0;
    end else begin
      if (fr) level--;
      if (acc) begin
        level++;
        sb_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_regwrite"}, 32'(bus.RegWriteW), 32'd0);
    check({tag, "_alu"}, bus.ALUResultW, 32'd0);
    check({tag, "_pc4"}, bus.PCPlus4W, 32'd0);
    check({tag, "_rd"}, 32'(bus.RdW), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    level = 0;
    rst   = 1'b1;
    bus.in_valid   = 1'b0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;
    bus.ALUResultM = '0;
    bus.ReadDataM  = '0;
    bus.PCPlus4M   = '0;
    bus.RdM        = '0;
    bus.RegWriteM  = 1'b0;
    bus.ResultSrcM = '0;
    bus.WD3SrcM    = 1'b0;
    #2;
    check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // streaming at full rate
    step(1, 32'h10, 5'd1, 1, 1, 0);
    step(1, 32'h20, 5'd2, 1, 1, 0);
    step(1, 32'h30, 5'd3, 1, 1, 0);
    step(1, 32'h40, 5'd4, 1, 1, 0);
    step(0, 32'h0, 5'd0, 0, 1, 0);
    step(0, 32'h0, 5'd0, 0, 1, 0);

    // stall into FULL, blocked input, then drain in order
    step(1, 32'hAAAA, 5'd3, 1, 0, 0);
    step(1, 32'hBBBB, 5'd4, 1, 0, 0);
    step(0, 32'h0, 5'd0, 0, 0, 0);
    step(1, 32'hCCCC, 5'd6, 1, 0, 0);
    step(0, 32'h0, 5'd0, 0, 1, 0);
    step(0, 32'h0, 5'd0, 0, 1, 0);
    step(0, 32'h0, 5'd0, 0, 1, 0);

    // x0 write suppression
    step(1, 32'h1, 5'd0, 1, 1, 0);
    step(1, 32'h2, 5'd5, 1, 1, 0);
    step(0, 32'h0, 5'd0, 0, 1, 0);
    step(0, 32'h0, 5'd0, 0, 1, 0);

    // flush from FULL with fire, and from ONE with accept
    step(1, 32'hA1, 5'd7, 1, 0, 0);
    step(1, 32'hB1, 5'd8, 1, 0, 0);
    step(0, 32'h0, 5'd0, 0, 1, 1);
    step(0, 32'h0, 5'd0, 0, 1, 0);
    step(1, 32'hC1, 5'd9, 1, 0, 0);
    step(1, 32'hD1, 5'd10, 1, 0, 1);
    step(0, 32'h0, 5'd0, 0, 1, 0);

    // asynchronous reset while FULL
    step(1, 32'hE1, 5'd11, 1, 0, 0);
    step(1, 32'hE2, 5'd12, 1, 0, 0);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    sb_q.delete();
    level = 0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1, 32'h55, 5'd13, 1, 0, 0);
    check("post_rst_alu", bus.ALUResultW, 32'h55);
    step(0, 32'h0, 5'd0, 0, 1, 0);
    step(0, 32'h0, 5'd0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, $urandom, 5'($urandom % 8), 1'($urandom),
           ($urandom % 3) != 0, ($urandom % 25) == 0);
    end
    for (int i = 0; i < 4; i++) step(0, 32'h0, 5'd0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_memwb_skid.md
PIPELINE_MEMWB_SKID -- requirements
Module: pipeline_memwb_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of ALU result, read data and PC+4.
REQ-002 SHALL have parameter RD_W, default 5, destination register index width.
REQ-003 SHALL have a single clock domain; reset is asynchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  MEM stage presents a valid instruction.
REQ-007 in_ready  out  1  stage can accept; registered, never combinationally dependent on out_ready.
REQ-008 flush  in  1  kill all held instructions (trap/redirect).
REQ-009 ALUResultM, ReadDataM, PCPlus4M  in  WIDTH each  MEM datapath payload.
REQ-010 RdM  in  RD_W  destination register.
REQ-011 RegWriteM  in  1; ResultSrcM  in  2; WD3SrcM  in  1  MEM control payload.
REQ-012 out_valid  out  1  WB payload valid.
REQ-013 out_ready  in  1  WB (register file / result mux) consumes this cycle.
REQ-014 ALUResultW, ReadDataW, PCPlus4W  out  WIDTH; RdW  out  RD_W; RegWriteW  out  1; ResultSrcW  out  2; WD3SrcW  out  1  WB payload.

Function
REQ-015 accept = in_valid & in_ready; fire = out_valid & out_ready.
REQ-016 Storage SHALL be two payload entries: main (drives W outputs) and skid.
REQ-017 State machine SHALL have states EMPTY, ONE, FULL; out_valid = (state != EMPTY); in_ready = (state != FULL).
REQ-018 EMPTY: accept -> ONE, main <= input; else stay.
REQ-019 ONE: accept & fire -> ONE, main <= input; fire only -> EMPTY; accept only -> FULL, skid <= input; neither -> stay.
REQ-020 FULL: no accept possible; fire -> ONE, main <= skid; else stay with both entries unchanged.
REQ-021 Latency SHALL be one cycle: payload accepted at edge N is on W outputs with out_valid=1 after edge N.
REQ-022 While out_valid=1 and out_ready=0, all W outputs SHALL remain stable.
REQ-023 Throughput SHALL be one instruction per cycle when out_ready stays high.
REQ-024 Order SHALL be preserved; no payload dropped or duplicated absent flush.
REQ-025 Captured RegWrite SHALL be RegWriteM & (RdM != 0); writes to x0 suppressed.
REQ-026 RegWriteW SHALL be 0 whenever out_valid=0; other W payload is don't-care then.
REQ-027 flush SHALL force next state EMPTY from any state, overriding simultaneous accept and fire; the accepted instruction is discarded.
REQ-028 During flush cycle, in_ready keeps its registered value; after flush edge in_ready=1, out_valid=0.
REQ-029 in_valid with in_ready=0 SHALL have no effect; upstream holds payload.

Reset
REQ-030 rst=1 SHALL immediately force state EMPTY, out_valid=0, in_ready=1, RegWriteW=0, all other W outputs and both entries 0.
REQ-031 Reset asserted mid-transfer SHALL discard both entries; first edge after release with in_valid=1 accepts normally.

Verification
REQ-032 Stream 4 instrs, out_ready=1: ALUResultM=0x10,0x20,0x30,0x40 -> ALUResultW same sequence one cycle later, out_valid continuous, in_ready stays 1.
REQ-033 Stall: accept A (0xAAAA), B (0xBBBB) with out_ready=0 -> FULL, in_ready=0, W holds A; out_ready=1 two cycles -> A then B, then EMPTY.
REQ-034 RegWriteM=1, RdM=0 -> RegWriteW=0; RegWriteM=1, RdM=5 -> RegWriteW=1, RdW=5.
REQ-035 FULL with flush=1 and out_ready=1 same cycle -> next cycle out_valid=0, in_ready=1, RegWriteW=0; ONE with flush and accept -> new input discarded.
REQ-036 Assert rst asynchronously between edges while FULL -> outputs zero immediately, in_ready=1; release, accept 0x55 -> ALUResultW=0x55 next cycle.
REQ-037 Random in_valid/out_ready/flush vs scoreboard model: order, no loss, W stability under stall, in_ready never combinational from out_ready.
